mc_control_fsm: RTL

Multicycle control unit that sequences the IR / register-file / A-B latch / ALU datapath and the PC and memory around it. A Moore FSM decodes the latched opcode and funct and drives every datapath strobe and mux select one state per cycle. It supports the team's MIPS subset: LW, SW, J, JAL, JR, BNE, XORI, ADD, SUB and SLT. Memory states wait on a ready handshake, and the block keeps a retired-instruction counter for the bench.

---
 rtl/mc_control_fsm.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control FSM: drives datapath strobes/selects and counts retired instructions.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN: unknown instructions lock into a TRAP state instead of retiring as NOPs.
module mc_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_we,
    output logic             ir_we,
    output logic [1:0]       reg_dst,
    output logic             reg_we,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_e;

    state_e           state_q, state_d;
    logic             retire;
    logic             unknown;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + CNT_ONE;
            end
        end
    end

    assign instr_count = count_q;

    // retire marks every terminal-state exit into FETCH
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unknown = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_XORI:      state_d = S_EXEC_I;
                    OP_BNE:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_SLT: state_d = S_EXEC_R;
                            FN_JR:                  state_d = S_JR;
                            default:                unknown = 1'b1;
                        endcase
                    end
                    default: unknown = 1'b1;
                endcase
                if (unknown) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
                    retire  = 1'b1;
`endif
                end
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_dst    = 2'b00;
        reg_we     = 1'b0;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_rd = 1'b1;
                ir_we  = mem_ready;
                pc_we  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b10;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                reg_dst    = 2'b01;
                mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
                mem_we = 1'b1;
                iord   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b01;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_R_WB:     reg_we = 1'b1;
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_XOR;
            end
            S_I_WB: begin
                reg_we  = 1'b1;
                reg_dst = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_we     = ~zero;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = 2'b10;
            end
            S_JAL: begin
                pc_we      = 1'b1;
                pc_src     = 2'b10;
                reg_we     = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
            end
            S_JR: begin
                pc_we  = 1'b1;
                pc_src = 2'b11;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     illegal = 1'b1;
`endif
            default: ;
        endcase
        // reset is sampled synchronously but outputs must go quiet in the same cycle
        if (!rst_n) begin
            pc_we      = 1'b0;
            pc_src     = 2'b00;
            iord       = 1'b0;
            mem_rd     = 1'b0;
            mem_we     = 1'b0;
            ir_we      = 1'b0;
            reg_dst    = 2'b00;
            reg_we     = 1'b0;
            mem_to_reg = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = ALU_ADD;
            illegal    = 1'b0;
        end
    end

endmodule
